invaders_game_ctrl: RTL
=======================

Name: invaders_game_ctrl

Overview:
Central game-state controller for the invaders game. It runs in the pixel-clock domain and detects collisions pixel by pixel during the scan. It owns the alien alive matrix, score, lives and wave counter, and sequences the game through attract, play, death, wave-clear and game-over. It is the parametrised successor to the fixed wiring in the top level, where lives and score are constants and there is no hit feedback. It drives `hit_alien` on the laser, `alive_matrix` on the formation, and `score`/`lives` on the HUD.

Parameters:
- NUM_ROWS, 3, alien rows.
- NUM_COLUMNS, 5, alien columns.
- START_LIVES, 3, lives loaded at game start; must be >= 1 and fit in LIVES_W.
- LIVES_W, 2, width of `lives`.
- SCORE_W, 10, width of `score` (binary, saturating).
- POINT_UNIT, 10, points per row weight. A kill in row r scores (NUM_ROWS - r) * POINT_UNIT; row 0 is the top row.
- WAVE_W, 4, width of `wave` (wraps).
- DEATH_FRAMES, 60, frames spent in DYING.
- CLEAR_FRAMES, 30, frames spent in WAVE_CLEAR.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_tick, input, 1, one-cycle pulse once per frame at the start of vblank.
- pixel_valid, input, 1, display_on; collisions are sampled only when this is 1.
- start, input, 1, start button (already synchronised); the block edge-detects it.
- laser_pix, input, 1, laser graphic at the current pixel.
- alien_pix, input, 1, live-alien graphic at the current pixel.
- alien_row, input, $clog2(NUM_ROWS), row of the alien under the pixel; valid when alien_pix=1.
- alien_col, input, $clog2(NUM_COLUMNS), column of the alien under the pixel; valid when alien_pix=1.
- cannon_pix, input, 1, cannon graphic at the current pixel.
- bomb_pix, input, 1, alien bomb graphic at the current pixel.
- aliens_landed, input, 1, level signal: formation has reached the cannon line.
- alive_matrix, output, NUM_ROWS*NUM_COLUMNS, alive bits; bit index = row*NUM_COLUMNS + col.
- kill_valid, output, 1, one-cycle pulse when an alien is destroyed.
- kill_row, output, $clog2(NUM_ROWS), row of the destroyed alien; held until the next kill.
- kill_col, output, $clog2(NUM_COLUMNS), column of the destroyed alien; held until the next kill.
- laser_hit, output, 1, one-cycle pulse to the laser; same cycle as kill_valid.
- score, output, SCORE_W, current score.
- lives, output, LIVES_W, remaining lives.
- wave, output, WAVE_W, wave number; 0 on the first wave.
- state, output, 3, state code: ATTRACT=0, PLAY=1, DYING=2, WAVE_CLEAR=3, GAME_OVER=4.
- playing, output, 1, 1 only in PLAY; movement and shooting are gated by this.

Behaviour:
Reset values:
- state=ATTRACT, alive_matrix all ones, score=0, lives=START_LIVES, wave=0.
- kill_valid=0, laser_hit=0, kill_row=0, kill_col=0, playing=0.
- Frame counter and all per-frame flags cleared.
- Reset is asynchronous and overrides everything, including mid-DYING or mid-WAVE_CLEAR.

Start edge:
- start_rise = start & ~start_q (registered).
- Acted on only in ATTRACT or GAME_OVER. Next edge: score=0, lives=START_LIVES, wave=0, alive_matrix all ones, state=PLAY.

Alien kill (PLAY only):
- Condition: pixel_valid & laser_pix & alien_pix & alive bit[row,col]=1 & kill_done=0.
- On the next clk edge:
  - clear that alive bit;
  - pulse kill_valid and laser_hit for exactly 1 cycle;
  - latch kill_row/kill_col;
  - add points to score, saturating at 2^SCORE_W-1;
  - set kill_done.
- kill_done blocks further kills until frame_tick clears it: at most one kill per frame.
- An alien_pix whose alive bit is already 0 is ignored.

Player hit (PLAY only):
- pixel_valid & cannon_pix & bomb_pix sets hit_flag (sticky until frame_tick).
- A kill and a hit in the same frame are both recorded.

Transitions on frame_tick (state changes only on frame_tick, except the start edge):
- PLAY, first matching rule applies:
  1. hit_flag: lives -= 1, frame counter=0, go to DYING.
  2. else aliens_landed: lives=0, go to GAME_OVER.
  3. else alive_matrix==0: frame counter=0, go to WAVE_CLEAR.
  4. else stay in PLAY.
- DYING: count frames. After DEATH_FRAMES ticks:
  - lives==0: go to GAME_OVER;
  - else alive_matrix==0: go to WAVE_CLEAR (counter reset);
  - else go to PLAY.
- WAVE_CLEAR: after CLEAR_FRAMES ticks, alive_matrix all ones, wave += 1 (wrapping), go to PLAY.
- GAME_OVER: score and lives hold until a start edge.
- frame_tick always clears kill_done and hit_flag.
- lives never underflows; decrement only occurs when lives >= 1.

Collision sampling:
- Collision inputs are ignored outside PLAY and when pixel_valid=0.
- Latency from a collision pixel to kill_valid is 1 cycle.

Test Plan:
- Reset, then release -> state=0, lives=3, score=0, alive_matrix=15'h7FFF, playing=0.
- start 0->1, held 5 cycles -> one start edge, state=1 next cycle. In PLAY: laser_pix=alien_pix=pixel_valid=1, row 0, col 2 -> next cycle kill_valid=laser_hit=1 for 1 cycle, alive_matrix=15'h7FFB, score=30. A second collision on row 2 col 0 in the same frame -> no change. After frame_tick, a row 2 kill -> score=40.
- cannon_pix=bomb_pix=1 mid-frame, then frame_tick -> state=2, lives=2. After 60 ticks -> state=1. Repeat twice -> after the third death state=4, lives=0. start edge -> state=1, lives=3, score=0.
- Kill all 15 aliens over 15 frames -> next frame_tick state=3. After 30 ticks -> alive_matrix=15'h7FFF, wave=1, state=1.
- Last alien killed and hit in the same frame -> DYING, lives=2. After 60 ticks -> WAVE_CLEAR -> PLAY with wave=1.
- SCORE_W=6: three row-0 kills -> score=30, 60, 63 (saturated). aliens_landed=1 at frame_tick -> state=4, lives=0. rst_n asserted mid-DYING -> immediate reset values.

Source files
------------

// File: rtl/invaders_game_if.sv
// Signal bundle between the video/sprite side and the game-state controller.
// The master drives scan-time pixel information; the slave returns game state.
interface invaders_game_if #(
    parameter int NUM_ROWS    = 3,
    parameter int NUM_COLUMNS = 5,
    parameter int LIVES_W     = 2,
    parameter int SCORE_W     = 10,
    parameter int WAVE_W      = 4
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;

    logic                            frame_tick;
    logic                            pixel_valid;
    logic                            start;
    logic                            laser_pix;
    logic                            alien_pix;
    logic [ROW_W-1:0]                alien_row;
    logic [COL_W-1:0]                alien_col;
    logic                            cannon_pix;
    logic                            bomb_pix;
    logic                            aliens_landed;

    logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix;
    logic                            kill_valid;
    logic [ROW_W-1:0]                kill_row;
    logic [COL_W-1:0]                kill_col;
    logic                            laser_hit;
    logic [SCORE_W-1:0]              score;
    logic [LIVES_W-1:0]              lives;
    logic [WAVE_W-1:0]               wave;
    logic [2:0]                      state;
    logic                            playing;

    modport master (
        output frame_tick, pixel_valid, start, laser_pix, alien_pix, alien_row, alien_col,
               cannon_pix, bomb_pix, aliens_landed,
        input  alive_matrix, kill_valid, kill_row, kill_col, laser_hit, score, lives, wave,
               state, playing
    );

    modport slave (
        input  frame_tick, pixel_valid, start, laser_pix, alien_pix, alien_row, alien_col,
               cannon_pix, bomb_pix, aliens_landed,
        output alive_matrix, kill_valid, kill_row, kill_col, laser_hit, score, lives, wave,
               state, playing
    );
endinterface

// File: rtl/invaders_game_ctrl.sv
// Game-state controller: per-pixel collision detection, alive matrix, score, lives,
// wave counter and the attract/play/dying/wave-clear/game-over sequencer.
module invaders_game_ctrl #(
    parameter int NUM_ROWS     = 3,
    parameter int NUM_COLUMNS  = 5,
    parameter int START_LIVES  = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_W      = 10,
    parameter int POINT_UNIT   = 10,
    parameter int WAVE_W       = 4,
    parameter int DEATH_FRAMES = 60,
    parameter int CLEAR_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    invaders_game_if.slave   ctrl_if
);
    localparam int NUM_ALIENS = NUM_ROWS * NUM_COLUMNS;
    localparam int ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W      = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int CNT_MAX    = (DEATH_FRAMES > CLEAR_FRAMES) ? DEATH_FRAMES : CLEAR_FRAMES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SUM_W      = SCORE_W + 16;

    typedef enum logic [2:0] {
        ST_ATTRACT    = 3'd0,
        ST_PLAY       = 3'd1,
        ST_DYING      = 3'd2,
        ST_WAVE_CLEAR = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    state_e                state_q;
    logic [NUM_ALIENS-1:0] alive_q;
    logic [SCORE_W-1:0]    score_q;
    logic [LIVES_W-1:0]    lives_q;
    logic [WAVE_W-1:0]     wave_q;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic                  kill_done_q;
    logic                  hit_flag_q;
    logic                  start_q;
    logic                  kill_valid_q;
    logic [ROW_W-1:0]      kill_row_q;
    logic [COL_W-1:0]      kill_col_q;
    logic                  playing_q;

    logic                  start_rise;
    logic                  alien_in_range;
    int                    alien_idx;
    logic [NUM_ALIENS-1:0] kill_mask;
    logic                  kill_d;
    logic                  hit_d;
    logic [SUM_W-1:0]      score_sum;
    logic [SCORE_W-1:0]    score_d;
    logic                  death_done;
    logic                  clear_done;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latches.
    always_comb begin
        start_rise     = ctrl_if.start & ~start_q;
        alien_in_range = (int'(ctrl_if.alien_row) < NUM_ROWS) &&
                         (int'(ctrl_if.alien_col) < NUM_COLUMNS);
        alien_idx      = int'(ctrl_if.alien_row) * NUM_COLUMNS + int'(ctrl_if.alien_col);
        // One-hot select keeps stray row/col codes from aliasing onto a real alien.
        kill_mask      = alien_in_range ? (NUM_ALIENS'(1) << alien_idx) : '0;
        kill_d         = (state_q == ST_PLAY) & ctrl_if.pixel_valid & ctrl_if.laser_pix &
                         ctrl_if.alien_pix & (|(alive_q & kill_mask)) & ~kill_done_q;
        hit_d          = (state_q == ST_PLAY) & ctrl_if.pixel_valid & ctrl_if.cannon_pix &
                         ctrl_if.bomb_pix;
        score_sum      = SUM_W'(score_q) +
                         SUM_W'((NUM_ROWS - int'(ctrl_if.alien_row)) * POINT_UNIT);
        score_d        = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
        death_done     = (frame_cnt_q == CNT_W'(DEATH_FRAMES - 1));
        clear_done     = (frame_cnt_q == CNT_W'(CLEAR_FRAMES - 1));
    end

    // NOTE: sequential state uses non-blocking assignments; later assignments in this block
    // deliberately override earlier ones (start edge over frame-tick housekeeping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ATTRACT;
            alive_q      <= '1;
            score_q      <= '0;
            lives_q      <= LIVES_W'(START_LIVES);
            wave_q       <= '0;
            frame_cnt_q  <= '0;
            kill_done_q  <= 1'b0;
            hit_flag_q   <= 1'b0;
            start_q      <= 1'b0;
            kill_valid_q <= 1'b0;
            kill_row_q   <= '0;
            kill_col_q   <= '0;
            playing_q    <= 1'b0;
        end else begin
            start_q      <= ctrl_if.start;
            kill_valid_q <= 1'b0;

            if (ctrl_if.frame_tick) begin
                kill_done_q <= 1'b0;
                hit_flag_q  <= 1'b0;
            end
            if (kill_d) begin
                alive_q      <= alive_q & ~kill_mask;
                kill_valid_q <= 1'b1;
                kill_row_q   <= ctrl_if.alien_row;
                kill_col_q   <= ctrl_if.alien_col;
                score_q      <= score_d;
                kill_done_q  <= 1'b1;
            end
            if (hit_d) hit_flag_q <= 1'b1;

            if (start_rise && (state_q == ST_ATTRACT || state_q == ST_GAME_OVER)) begin
                state_q     <= ST_PLAY;
                playing_q   <= 1'b1;
                score_q     <= '0;
                lives_q     <= LIVES_W'(START_LIVES);
                wave_q      <= '0;
                alive_q     <= '1;
                frame_cnt_q <= '0;
                kill_done_q <= 1'b0;
                hit_flag_q  <= 1'b0;
            end else if (ctrl_if.frame_tick) begin
                unique case (state_q)
                    ST_PLAY: begin
                        if (hit_flag_q) begin
                            if (lives_q != '0) lives_q <= lives_q - LIVES_W'(1);
                            frame_cnt_q <= '0;
                            state_q     <= ST_DYING;
                            playing_q   <= 1'b0;
                        end else if (ctrl_if.aliens_landed) begin
                            lives_q   <= '0;
                            state_q   <= ST_GAME_OVER;
                            playing_q <= 1'b0;
                        end else if (alive_q == '0) begin
                            frame_cnt_q <= '0;
                            state_q     <= ST_WAVE_CLEAR;
                            playing_q   <= 1'b0;
                        end
                    end
                    ST_DYING: begin
                        if (!death_done) begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end else if (lives_q == '0) begin
                            state_q <= ST_GAME_OVER;
                        end else if (alive_q == '0) begin
                            frame_cnt_q <= '0;
                            state_q     <= ST_WAVE_CLEAR;
                        end else begin
                            state_q   <= ST_PLAY;
                            playing_q <= 1'b1;
                        end
                    end
                    ST_WAVE_CLEAR: begin
                        if (!clear_done) begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end else begin
                            alive_q   <= '1;
                            wave_q    <= wave_q + WAVE_W'(1);
                            state_q   <= ST_PLAY;
                            playing_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ctrl_if.alive_matrix = alive_q;
    assign ctrl_if.kill_valid   = kill_valid_q;
    assign ctrl_if.laser_hit    = kill_valid_q;
    assign ctrl_if.kill_row     = kill_row_q;
    assign ctrl_if.kill_col     = kill_col_q;
    assign ctrl_if.score        = score_q;
    assign ctrl_if.lives        = lives_q;
    assign ctrl_if.wave         = wave_q;
    assign ctrl_if.state        = state_q;
    assign ctrl_if.playing      = playing_q;
endmodule
